drive_arbiter: RTL

Command arbiter and motion sequencer for the two-stepper drive. It decodes command bytes from the UART receiver and arbitrates between manual Bluetooth control and the autonomous wall-avoidance sequence. It drives the shared `en`/`direction` inputs of both `pmod_step_interface` instances from registered outputs. It sits between `UART_rs232_rx`/`bi_chang` and the two motor interfaces.

---
 rtl/drive_arbiter_if.sv | 25 ++
 rtl/drive_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/drive_arbiter_if.sv
// Bundle between the UART/sensor front end and the drive arbiter.
// slave is the arbiter side; master is the environment driving commands.
interface drive_arbiter_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       is_wall;
    logic       motor_en;
    logic       motor_dir;
    logic       motor_dir2;
    logic [1:0] mode;
    logic       busy;
    logic [2:0] state_dbg;

    // rx_data is qualified by the single-cycle rx_done strobe; there is no
    // back-pressure, so every strobed byte is consumed on the edge it is seen.
    modport slave (
        input  rx_data, rx_done, is_wall,
        output motor_en, motor_dir, motor_dir2, mode, busy, state_dbg
    );

    modport master (
        output rx_data, rx_done, is_wall,
        input  motor_en, motor_dir, motor_dir2, mode, busy, state_dbg
    );
endinterface

// File: rtl/drive_arbiter.sv
// Command arbiter and motion sequencer for the two-stepper drive.
// Optional manual-mode command watchdog: define DRIVE_ARBITER_WATCHDOG_EN.
module drive_arbiter #(
    parameter int BACK_CYCLES = 200_000_000,
    parameter int TURN_CYCLES = 200_000_000,
    parameter int WDOG_CYCLES = 100_000_000,
    parameter int CNT_W       = 28
) (
    input  logic           Clk,
    input  logic           Rst_n,
    drive_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MANUAL    = 3'd1,
        S_AUTO_FWD  = 3'd2,
        S_AUTO_BACK = 3'd3,
        S_AUTO_TURN = 3'd4
    } state_t;

    // Motion encodings as {en, dir, dir2}.
    localparam logic [2:0] MOT_FWD   = 3'b101;
    localparam logic [2:0] MOT_BACK  = 3'b110;
    localparam logic [2:0] MOT_LEFT  = 3'b100;
    localparam logic [2:0] MOT_RIGHT = 3'b111;
    localparam logic [2:0] MOT_STOP  = 3'b011;

    localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
`ifdef DRIVE_ARBITER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
`endif

    // The shared counter must be able to reach the longest phase length.
    if ((64'(BACK_CYCLES) > (64'd1 << CNT_W)) || (64'(TURN_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(WDOG_CYCLES) > (64'd1 << CNT_W)) || (BACK_CYCLES < 1) || (TURN_CYCLES < 1) ||
        (WDOG_CYCLES < 1)) begin : g_bad_params
        $error("drive_arbiter: CNT_W too small or phase length below 1");
    end

    state_t           state_q, state_d;
    logic [2:0]       motion_q, motion_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       out_q, out_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;

    logic             is_move;
    logic             is_stop;
    logic             is_auto;
    logic [2:0]       move_code;

    always_comb begin
        is_move   = 1'b0;
        is_stop   = 1'b0;
        is_auto   = 1'b0;
        move_code = MOT_STOP;
        if (bus.rx_done) begin
            case (bus.rx_data)
                8'h46: begin is_move = 1'b1; move_code = MOT_FWD;   end
                8'h42: begin is_move = 1'b1; move_code = MOT_BACK;  end
                8'h4C: begin is_move = 1'b1; move_code = MOT_LEFT;  end
                8'h52: begin is_move = 1'b1; move_code = MOT_RIGHT; end
                8'h53: is_stop = 1'b1;
                8'h41: is_auto = 1'b1;
                default: ;
            endcase
        end
    end

    // Commands take priority over is_wall and phase expiry. 'A' inside an
    // auto state is not a command at all, so the sequence keeps running.
    always_comb begin
        state_d  = state_q;
        motion_d = motion_q;
        cnt_d    = cnt_q;
        if (is_move) begin
            state_d  = S_MANUAL;
            motion_d = move_code;
            cnt_d    = '0;
        end else if (is_stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (is_auto && (state_q == S_IDLE || state_q == S_MANUAL)) begin
            state_d = S_AUTO_FWD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: cnt_d = '0;
                S_MANUAL: begin
`ifdef DRIVE_ARBITER_WATCHDOG_EN
                    if (cnt_q == WDOG_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
                S_AUTO_FWD: begin
                    cnt_d = '0;
                    if (bus.is_wall) begin
                        state_d = S_AUTO_BACK;
                    end
                end
                S_AUTO_BACK: begin
                    if (cnt_q == BACK_LAST) begin
                        state_d = S_AUTO_TURN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_AUTO_TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        state_d = S_AUTO_FWD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    always_comb begin
        out_d  = MOT_STOP;
        mode_d = 2'd0;
        busy_d = 1'b0;
        case (state_d)
            S_MANUAL: begin
                out_d  = motion_d;
                mode_d = 2'd1;
            end
            S_AUTO_FWD: begin
                out_d  = MOT_FWD;
                mode_d = 2'd2;
            end
            S_AUTO_BACK: begin
                out_d  = MOT_BACK;
                mode_d = 2'd2;
                busy_d = 1'b1;
            end
            S_AUTO_TURN: begin
                out_d  = MOT_LEFT;
                mode_d = 2'd2;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            motion_q <= MOT_STOP;
            cnt_q    <= '0;
            out_q    <= MOT_STOP;
            mode_q   <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            motion_q <= motion_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.motor_en   = out_q[2];
    assign bus.motor_dir  = out_q[1];
    assign bus.motor_dir2 = out_q[0];
    assign bus.mode       = mode_q;
    assign bus.busy       = busy_q;
    assign bus.state_dbg  = state_q;

endmodule
